cms_trace_controller: RTL and testbench
=======================================

# cms_trace_controller

Sequencing controller for the continuous monitoring system (CMS) trace path. It sits between the core's retired-instruction stream and the trace FIFO. It owns the CMS control registers (trigger addresses, monitored range, WFI stop, clock counter, last-write timestamp) and runs the trace state machine that decides, per retired instruction, whether a trace item is written, dropped or ignored.

## Interface
Parameters:
- XLEN, 64, PC and control-data width.
- CTRL_ADDR_WIDTH, 8, control address width.
- DROP_COUNTER_WIDTH, 16, width of the saturating dropped-item counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ctrl_addr  in  8  control register address.
- ctrl_wdata  in  64  control write data.
- ctrl_write_enable  in  1  control write strobe, 1 cycle per write.
- ctrl_read_enable  in  1  control read strobe.
- ctrl_rdata  out  64  read data, registered.
- ctrl_rdata_valid  out  1  high the cycle after ctrl_read_enable.
- instr_valid  in  1  one instruction retired this cycle.
- pc  in  64  PC of retired instruction.
- instr  in  32  retired instruction word.
- filter_match  in  1  trace filter marks instruction as a trace item.
- fifo_full  in  1  trace FIFO cannot accept a write this cycle.
- trace_write  out  1  registered FIFO write strobe.
- trace_pc  out  64  PC of written item.
- trace_instr  out  32  instruction of written item.
- trace_timestamp  out  64  clk_counter value at retirement.
- tracing  out  1  state == TRACING.
- wfi_stopped  out  1  state == STOPPED.

## Operation
- Register map (write / read): 0 START_EN[0], 1 END_EN[0], 2 START_ADDR, 3 END_ADDR, 4 LOWER_EN[0], 5 UPPER_EN[0], 6 LOWER, 7 UPPER, 8 WFI_STOPPED, 9 CLK_COUNTER (RO), 10 LAST_WRITE_TIMESTAMP (RO), 11 DROPPED_COUNT (RO, zero-extended). Writes to RO or unmapped addresses are ignored. Unmapped reads return 0.
- All config registers reset to 0.
- clk_counter: 0 at reset, +1 every cycle, wraps 2^64-1 → 0.
- States: WAIT_START (reset state), TRACING, STOPPED.
- WAIT_START → TRACING when START_EN=0, or when instr_valid & pc==START_ADDR. The trigger instruction itself is eligible.
- TRACING → WAIT_START when END_EN=1 & instr_valid & pc==END_ADDR. The end instruction is eligible.
- TRACING or WAIT_START → STOPPED on instr_valid & instr==32'h10500073 (WFI). The WFI instruction is not eligible. WFI takes priority over a start or end match in the same cycle.
- Write to WFI_STOPPED with nonzero data → STOPPED. Write with 0 while STOPPED → WAIT_START.
- A WFI retiring in the same cycle as a release write wins: the state stays STOPPED.
- Eligible = instr_valid & filter_match & (LOWER_EN ? pc>=LOWER : 1) & (UPPER_EN ? pc<=UPPER : 1) & (state==TRACING | start trigger hit this cycle). Comparisons are unsigned 64-bit.
- Eligible & !fifo_full → write issued. LAST_WRITE_TIMESTAMP ← clk_counter of the retirement cycle.
- Eligible & fifo_full → item dropped. DROPPED_COUNT increments and saturates at all-ones.
- A control write in the same cycle as a retirement takes effect the next cycle. The retirement uses the old register values.

## Timing
- trace_write, trace_pc, trace_instr and trace_timestamp are registered: valid 1 cycle after the retirement cycle. trace_write is high for exactly 1 cycle per item.
- fifo_full is sampled in the retirement cycle.
- ctrl_rdata and ctrl_rdata_valid appear 1 cycle after ctrl_read_enable. A read and a write to the same address in one cycle returns the old value.
- tracing and wfi_stopped are decoded from the state register, so they change 1 cycle after the triggering event.
- Reset values: all outputs 0. State is WAIT_START. With START_EN=0 the block enters TRACING on the first cycle after reset deassertion.
- Reset asserted mid-trace: state, registers and counters clear immediately. Any pending trace_write is cancelled.

## Test plan
- Default config after reset, filter_match=1, 3 retirements at pc 0x1000/0x1004/0x1008 → 3 trace_write pulses one cycle later with matching pc; LAST_WRITE_TIMESTAMP = counter at the 3rd retirement.
- START_EN=1, START_ADDR=0x2000, END_EN=1, END_ADDR=0x2010; retire 0x1ffc, 0x2000..0x2010, 0x2014 → only 0x2000..0x2010 written (5 items); state returns to WAIT_START.
- LOWER_EN=UPPER_EN=1, range 0x3000..0x30ff; retire 0x2ffc, 0x3000, 0x30ff, 0x3100 → only 0x3000 and 0x30ff written.
- fifo_full=1 during 4 eligible retirements → no trace_write, DROPPED_COUNT=4. Preload at 0xfffe plus 3 drops → saturates at 0xffff.
- Retire WFI (0x10500073) while tracing → no write for WFI, wfi_stopped=1 next cycle, later retirements ignored. Write 0 to address 8 → WAIT_START, then TRACING. WFI in the same cycle as the release write → stays STOPPED.
- Assert rst_n low mid-trace with a pending write → trace_write=0 and all registers 0 immediately. Read address 9 after 10 cycles out of reset → ctrl_rdata = counter value, ctrl_rdata_valid for 1 cycle.

Source files
------------

// File: rtl/cms_trace_controller.sv
// cms_trace_controller
//   Sequencing controller for the CMS trace path. It sits between the core's
//   retired-instruction stream and the trace FIFO. It owns the CMS control
//   registers and runs the trace state machine, which decides for each
//   retired instruction whether a trace item is written, dropped or ignored.
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   ctrl_addr/wdata     : control register address and write data
//   ctrl_write_enable   : one-cycle write strobe
//   ctrl_read_enable    : read strobe; ctrl_rdata/ctrl_rdata_valid follow one cycle later
//   instr_valid/pc/instr: retired instruction (at most one per cycle)
//   filter_match        : the trace filter marks this instruction as a trace item
//   fifo_full           : the trace FIFO cannot accept a write this cycle
//   trace_*             : registered FIFO write strobe and item payload
//   tracing/wfi_stopped : state decodes (TRACING / STOPPED)
module cms_trace_controller #(
  parameter int XLEN               = 64,
  parameter int CTRL_ADDR_WIDTH    = 8,
  parameter int DROP_COUNTER_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [XLEN-1:0]            ctrl_wdata,
  input  logic                       ctrl_write_enable,
  input  logic                       ctrl_read_enable,
  output logic [XLEN-1:0]            ctrl_rdata,
  output logic                       ctrl_rdata_valid,
  input  logic                       instr_valid,
  input  logic [XLEN-1:0]            pc,
  input  logic [31:0]                instr,
  input  logic                       filter_match,
  input  logic                       fifo_full,
  output logic                       trace_write,
  output logic [XLEN-1:0]            trace_pc,
  output logic [31:0]                trace_instr,
  output logic [XLEN-1:0]            trace_timestamp,
  output logic                       tracing,
  output logic                       wfi_stopped
);

  localparam logic [31:0] WFI_INSTR = 32'h1050_0073;

  localparam logic [CTRL_ADDR_WIDTH-1:0] A_START_EN   = CTRL_ADDR_WIDTH'(0);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_END_EN     = CTRL_ADDR_WIDTH'(1);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_START_ADDR = CTRL_ADDR_WIDTH'(2);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_END_ADDR   = CTRL_ADDR_WIDTH'(3);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_LOWER_EN   = CTRL_ADDR_WIDTH'(4);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_UPPER_EN   = CTRL_ADDR_WIDTH'(5);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_LOWER      = CTRL_ADDR_WIDTH'(6);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_UPPER      = CTRL_ADDR_WIDTH'(7);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_WFI_STOP   = CTRL_ADDR_WIDTH'(8);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_CLK_COUNT  = CTRL_ADDR_WIDTH'(9);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_LAST_TS    = CTRL_ADDR_WIDTH'(10);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_DROPPED    = CTRL_ADDR_WIDTH'(11);

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_TRACING    = 2'd1,
    ST_STOPPED    = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic                          start_en_q, start_en_d, end_en_q, end_en_d;
  logic                          lower_en_q, lower_en_d, upper_en_q, upper_en_d;
  logic [XLEN-1:0]               start_addr_q, start_addr_d, end_addr_q, end_addr_d;
  logic [XLEN-1:0]               lower_q, lower_d, upper_q, upper_d;
  logic [XLEN-1:0]               clk_counter_q, clk_counter_d;
  logic [XLEN-1:0]               last_ts_q, last_ts_d;
  logic [DROP_COUNTER_WIDTH-1:0] dropped_q, dropped_d;
  logic [XLEN-1:0]               ctrl_rdata_q, ctrl_rdata_d;
  logic                          ctrl_rdata_valid_q, ctrl_rdata_valid_d;
  logic                          trace_write_q, trace_write_d;
  logic [XLEN-1:0]               trace_pc_q, trace_pc_d;
  logic [31:0]                   trace_instr_q, trace_instr_d;
  logic [XLEN-1:0]               trace_ts_q, trace_ts_d;
  logic                          tracing_q, tracing_d, wfi_stopped_q, wfi_stopped_d;

  logic            is_wfi, start_hit, end_hit, in_range, eligible;
  logic            stop_write, release_write;
  logic [XLEN-1:0] read_value;

  // Every retirement decision is made against the register values held at
  // the start of the cycle; control writes land in the _d values only.
  always_comb begin
    is_wfi        = instr_valid && (instr == WFI_INSTR);
    // With START_EN clear the start trigger fires on any cycle in WAIT_START,
    // so the block drops straight into TRACING.
    start_hit     = (state_q == ST_WAIT_START) &&
                    (!start_en_q || (instr_valid && (pc == start_addr_q)));
    end_hit       = (state_q == ST_TRACING) && end_en_q && instr_valid && (pc == end_addr_q);
    in_range      = (!lower_en_q || (pc >= lower_q)) && (!upper_en_q || (pc <= upper_q));
    eligible      = instr_valid && filter_match && in_range && !is_wfi &&
                    ((state_q == ST_TRACING) || start_hit);
    stop_write    = ctrl_write_enable && (ctrl_addr == A_WFI_STOP) && (ctrl_wdata != '0);
    release_write = ctrl_write_enable && (ctrl_addr == A_WFI_STOP) && (ctrl_wdata == '0);

    state_d = state_q;
    case (state_q)
      // A WFI retiring alongside the release write keeps the block stopped.
      ST_STOPPED: if (release_write && !is_wfi) state_d = ST_WAIT_START;
      default: begin
        if (is_wfi || stop_write)     state_d = ST_STOPPED;
        else if (start_hit)           state_d = ST_TRACING;
        else if (end_hit)             state_d = ST_WAIT_START;
      end
    endcase
    tracing_d     = (state_d == ST_TRACING);
    wfi_stopped_d = (state_d == ST_STOPPED);

    clk_counter_d = clk_counter_q + 1'b1;

    trace_write_d = eligible && !fifo_full;
    trace_pc_d    = trace_pc_q;
    trace_instr_d = trace_instr_q;
    trace_ts_d    = trace_ts_q;
    last_ts_d     = last_ts_q;
    if (trace_write_d) begin
      trace_pc_d    = pc;
      trace_instr_d = instr;
      trace_ts_d    = clk_counter_q;
      last_ts_d     = clk_counter_q;
    end

    dropped_d = dropped_q;
    if (eligible && fifo_full && (dropped_q != {DROP_COUNTER_WIDTH{1'b1}}))
      dropped_d = dropped_q + 1'b1;

    start_en_d   = start_en_q;
    end_en_d     = end_en_q;
    lower_en_d   = lower_en_q;
    upper_en_d   = upper_en_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    lower_d      = lower_q;
    upper_d      = upper_q;
    if (ctrl_write_enable) begin
      case (ctrl_addr)
        A_START_EN:   start_en_d   = ctrl_wdata[0];
        A_END_EN:     end_en_d     = ctrl_wdata[0];
        A_START_ADDR: start_addr_d = ctrl_wdata;
        A_END_ADDR:   end_addr_d   = ctrl_wdata;
        A_LOWER_EN:   lower_en_d   = ctrl_wdata[0];
        A_UPPER_EN:   upper_en_d   = ctrl_wdata[0];
        A_LOWER:      lower_d      = ctrl_wdata;
        A_UPPER:      upper_d      = ctrl_wdata;
        default: ;
      endcase
    end

    // Reads see the pre-write register values, so a same-cycle read and
    // write of one address returns the old contents.
    case (ctrl_addr)
      A_START_EN:   read_value = XLEN'(start_en_q);
      A_END_EN:     read_value = XLEN'(end_en_q);
      A_START_ADDR: read_value = start_addr_q;
      A_END_ADDR:   read_value = end_addr_q;
      A_LOWER_EN:   read_value = XLEN'(lower_en_q);
      A_UPPER_EN:   read_value = XLEN'(upper_en_q);
      A_LOWER:      read_value = lower_q;
      A_UPPER:      read_value = upper_q;
      A_WFI_STOP:   read_value = XLEN'(state_q == ST_STOPPED);
      A_CLK_COUNT:  read_value = clk_counter_q;
      A_LAST_TS:    read_value = last_ts_q;
      A_DROPPED:    read_value = XLEN'(dropped_q);
      default:      read_value = '0;
    endcase
    ctrl_rdata_d       = ctrl_read_enable ? read_value : ctrl_rdata_q;
    ctrl_rdata_valid_d = ctrl_read_enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_WAIT_START;
      start_en_q         <= 1'b0;
      end_en_q           <= 1'b0;
      lower_en_q         <= 1'b0;
      upper_en_q         <= 1'b0;
      start_addr_q       <= '0;
      end_addr_q         <= '0;
      lower_q            <= '0;
      upper_q            <= '0;
      clk_counter_q      <= '0;
      last_ts_q          <= '0;
      dropped_q          <= '0;
      ctrl_rdata_q       <= '0;
      ctrl_rdata_valid_q <= 1'b0;
      trace_write_q      <= 1'b0;
      trace_pc_q         <= '0;
      trace_instr_q      <= '0;
      trace_ts_q         <= '0;
      tracing_q          <= 1'b0;
      wfi_stopped_q      <= 1'b0;
    end else begin
      state_q            <= state_d;
      start_en_q         <= start_en_d;
      end_en_q           <= end_en_d;
      lower_en_q         <= lower_en_d;
      upper_en_q         <= upper_en_d;
      start_addr_q       <= start_addr_d;
      end_addr_q         <= end_addr_d;
      lower_q            <= lower_d;
      upper_q            <= upper_d;
      clk_counter_q      <= clk_counter_d;
      last_ts_q          <= last_ts_d;
      dropped_q          <= dropped_d;
      ctrl_rdata_q       <= ctrl_rdata_d;
      ctrl_rdata_valid_q <= ctrl_rdata_valid_d;
      trace_write_q      <= trace_write_d;
      trace_pc_q         <= trace_pc_d;
      trace_instr_q      <= trace_instr_d;
      trace_ts_q         <= trace_ts_d;
      tracing_q          <= tracing_d;
      wfi_stopped_q      <= wfi_stopped_d;
    end
  end

  assign ctrl_rdata       = ctrl_rdata_q;
  assign ctrl_rdata_valid = ctrl_rdata_valid_q;
  assign trace_write      = trace_write_q;
  assign trace_pc         = trace_pc_q;
  assign trace_instr      = trace_instr_q;
  assign trace_timestamp  = trace_ts_q;
  assign tracing          = tracing_q;
  assign wfi_stopped      = wfi_stopped_q;

endmodule

// File: tb/tb_cms_trace_controller.sv
// tb_cms_trace_controller
//   Drives directed and randomized retirement/control traffic into
//   cms_trace_controller. A reference model predicts trace items, read data
//   and state flags into queues; a monitor pops and compares them as the DUT
//   presents its outputs.
module tb_cms_trace_controller;

  localparam logic [31:0] WFI      = 32'h1050_0073;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DROP_W   = 4;
  localparam int          DROP_MAX = (1 << DROP_W) - 1;

  logic        clk, rst_n;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_write_enable, ctrl_read_enable;
  logic [63:0] ctrl_rdata;
  logic        ctrl_rdata_valid;
  logic        instr_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        filter_match, fifo_full;
  logic        trace_write;
  logic [63:0] trace_pc;
  logic [31:0] trace_instr;
  logic [63:0] trace_timestamp;
  logic        tracing, wfi_stopped;

  cms_trace_controller #(
    .XLEN(64), .CTRL_ADDR_WIDTH(8), .DROP_COUNTER_WIDTH(DROP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .ctrl_read_enable(ctrl_read_enable),
    .ctrl_rdata(ctrl_rdata), .ctrl_rdata_valid(ctrl_rdata_valid),
    .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .filter_match(filter_match), .fifo_full(fifo_full),
    .trace_write(trace_write), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_timestamp(trace_timestamp), .tracing(tracing), .wfi_stopped(wfi_stopped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] ts;
  } trace_item_t;

  typedef struct {
    logic tr;
    logic st;
  } status_t;

  trace_item_t trace_q[$];
  logic [63:0] read_q[$];
  status_t     status_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain register copies plus two mode flags.
  logic        m_start_en, m_end_en, m_lower_en, m_upper_en;
  logic [63:0] m_start_addr, m_end_addr, m_lower, m_upper;
  logic [63:0] m_counter, m_last_ts;
  int          m_dropped;
  logic        m_tracing, m_stopped;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_vec++;
    if (actual !== required) begin
      n_err++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, actual, required, $time);
    end
  endtask

  task automatic modelReset();
    m_start_en = 0; m_end_en = 0; m_lower_en = 0; m_upper_en = 0;
    m_start_addr = 0; m_end_addr = 0; m_lower = 0; m_upper = 0;
    m_counter = 0; m_last_ts = 0; m_dropped = 0;
    m_tracing = 0; m_stopped = 0;
    trace_q.delete(); read_q.delete(); status_q.delete();
  endtask

  function automatic logic [63:0] readModel(input logic [7:0] a);
    case (a)
      8'd0:    return {63'd0, m_start_en};
      8'd1:    return {63'd0, m_end_en};
      8'd2:    return m_start_addr;
      8'd3:    return m_end_addr;
      8'd4:    return {63'd0, m_lower_en};
      8'd5:    return {63'd0, m_upper_en};
      8'd6:    return m_lower;
      8'd7:    return m_upper;
      8'd8:    return {63'd0, m_stopped};
      8'd9:    return m_counter;
      8'd10:   return m_last_ts;
      8'd11:   return 64'(m_dropped);
      default: return 64'd0;
    endcase
  endfunction

  // Drives one cycle of inputs, predicts its consequences, then advances to
  // 2 time units after the next rising edge.
  task automatic applyStimulus(input logic iv, input logic [63:0] p, input logic [31:0] ins,
                               input logic fm, input logic full,
                               input logic we, input logic [7:0] wa, input logic [63:0] wd,
                               input logic re, input logic [7:0] ra);
    logic wfi, in_range, start_cond, elig, nt, ns;
    trace_item_t it;
    status_t s;
    instr_valid = iv; pc = p; instr = ins; filter_match = fm; fifo_full = full;
    ctrl_write_enable = we; ctrl_addr = we ? wa : ra; ctrl_read_enable = re; ctrl_wdata = wd;
    if (we && re && wa != ra) ctrl_addr = wa;
    if (re) read_q.push_back(readModel(ctrl_addr));

    wfi        = iv && (ins == WFI);
    in_range   = (!m_lower_en || p >= m_lower) && (!m_upper_en || p <= m_upper);
    start_cond = !m_tracing && !m_stopped && (!m_start_en || (iv && p == m_start_addr));
    elig       = iv && fm && in_range && (m_tracing || start_cond) && !wfi;
    if (elig && !full) begin
      it.pc = p; it.instr = ins; it.ts = m_counter;
      trace_q.push_back(it);
      m_last_ts = m_counter;
    end
    if (elig && full) m_dropped = (m_dropped < DROP_MAX) ? m_dropped + 1 : DROP_MAX;

    nt = m_tracing; ns = m_stopped;
    if (m_stopped) begin
      if (we && ctrl_addr == 8'd8 && wd == 0 && !wfi) ns = 0;
    end else if (wfi || (we && ctrl_addr == 8'd8 && wd != 0)) begin
      ns = 1; nt = 0;
    end else if (start_cond) begin
      nt = 1;
    end else if (m_tracing && m_end_en && iv && p == m_end_addr) begin
      nt = 0;
    end
    m_tracing = nt; m_stopped = ns;

    if (we) begin
      case (ctrl_addr)
        8'd0: m_start_en = wd[0];
        8'd1: m_end_en = wd[0];
        8'd2: m_start_addr = wd;
        8'd3: m_end_addr = wd;
        8'd4: m_lower_en = wd[0];
        8'd5: m_upper_en = wd[0];
        8'd6: m_lower = wd;
        8'd7: m_upper = wd;
        default: ;
      endcase
    end
    s.tr = nt; s.st = ns;
    status_q.push_back(s);
    m_counter = m_counter + 1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic retire(input logic [63:0] p, input logic full);
    applyStimulus(1, p, NOP, 1, full, 0, 0, 0, 0, 0);
  endtask

  task automatic ctrlWrite(input logic [7:0] a, input logic [63:0] d);
    applyStimulus(0, 0, NOP, 0, 0, 1, a, d, 0, 0);
  endtask

  task automatic ctrlRead(input logic [7:0] a);
    applyStimulus(0, 0, NOP, 0, 0, 0, 0, 0, 1, a);
  endtask

  task automatic drainCheck(input string name);
    idle();
    idle();
    checkOutput(name, 64'(trace_q.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_trace_write"}, {63'd0, trace_write}, 64'd0);
    checkOutput({tag, "_trace_pc"}, trace_pc, 64'd0);
    checkOutput({tag, "_trace_ts"}, trace_timestamp, 64'd0);
    checkOutput({tag, "_tracing"}, {63'd0, tracing}, 64'd0);
    checkOutput({tag, "_wfi_stopped"}, {63'd0, wfi_stopped}, 64'd0);
    checkOutput({tag, "_rdata_valid"}, {63'd0, ctrl_rdata_valid}, 64'd0);
    checkOutput({tag, "_rdata"}, ctrl_rdata, 64'd0);
  endtask

  // Monitor: one step after every rising edge, compare whatever the DUT presents.
  always @(posedge clk) begin
    status_t s;
    trace_item_t it;
    logic [63:0] rd;
    #1;
    if (rst_n === 1'b1) begin
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        checkOutput("tracing", {63'd0, tracing}, {63'd0, s.tr});
        checkOutput("wfi_stopped", {63'd0, wfi_stopped}, {63'd0, s.st});
      end
      if (trace_write === 1'b1) begin
        if (trace_q.size() == 0) checkOutput("unexpected_trace_write", 64'd1, 64'd0);
        else begin
          it = trace_q.pop_front();
          checkOutput("trace_pc", trace_pc, it.pc);
          checkOutput("trace_instr", {32'd0, trace_instr}, {32'd0, it.instr});
          checkOutput("trace_timestamp", trace_timestamp, it.ts);
        end
      end
      if (ctrl_rdata_valid === 1'b1) begin
        if (read_q.size() == 0) checkOutput("unexpected_rdata_valid", 64'd1, 64'd0);
        else begin
          rd = read_q.pop_front();
          checkOutput("ctrl_rdata", ctrl_rdata, rd);
        end
      end
    end
  end

  initial begin
    logic [63:0] pcs [6];
    logic [7:0]  wa;
    logic [63:0] wd;
    pcs[0] = 64'h2000; pcs[1] = 64'h2010; pcs[2] = 64'h3000;
    pcs[3] = 64'h30ff; pcs[4] = 64'h2ffc; pcs[5] = 64'h3100;

    rst_n = 0;
    instr_valid = 0; pc = 0; instr = NOP; filter_match = 0; fifo_full = 0;
    ctrl_addr = 0; ctrl_wdata = 0; ctrl_write_enable = 0; ctrl_read_enable = 0;
    modelReset();
    @(posedge clk);
    #2;
    checkResetOutputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1;

    $display("[TB] default configuration, three retirements");
    retire(64'h1000, 0);
    retire(64'h1004, 0);
    retire(64'h1008, 0);
    ctrlRead(8'd10);
    drainCheck("default_drain");

    $display("[TB] start/end address triggers");
    ctrlWrite(8'd2, 64'h2000);
    ctrlWrite(8'd3, 64'h2010);
    ctrlWrite(8'd1, 64'd1);
    ctrlWrite(8'd0, 64'd1);
    retire(64'h2010, 0);
    retire(64'h1ffc, 0);
    for (int i = 0; i <= 4; i++) retire(64'h2000 + 64'(4 * i), 0);
    retire(64'h2014, 0);
    drainCheck("trigger_drain");

    $display("[TB] address range filter");
    ctrlWrite(8'd0, 64'd0);
    ctrlWrite(8'd1, 64'd0);
    ctrlWrite(8'd6, 64'h3000);
    ctrlWrite(8'd7, 64'h30ff);
    ctrlWrite(8'd4, 64'd1);
    ctrlWrite(8'd5, 64'd1);
    retire(64'h2ffc, 0);
    retire(64'h3000, 0);
    retire(64'h30ff, 0);
    retire(64'h3100, 0);
    drainCheck("range_drain");

    $display("[TB] drops and saturation");
    for (int i = 0; i < 4; i++) retire(64'h3010, 1);
    ctrlRead(8'd11);
    for (int i = 0; i < DROP_MAX; i++) retire(64'h3014, 1);
    ctrlRead(8'd11);
    drainCheck("drop_drain");

    $display("[TB] WFI stop and release");
    retire(64'h3020, 0);
    applyStimulus(1, 64'h3024, WFI, 1, 0, 0, 0, 0, 0, 0);
    retire(64'h3028, 0);
    ctrlRead(8'd8);
    ctrlWrite(8'd8, 64'd0);
    idle();
    retire(64'h302c, 0);
    applyStimulus(1, 64'h3030, WFI, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 64'h3034, WFI, 1, 0, 1, 8'd8, 64'd0, 0, 0);
    ctrlRead(8'd8);
    ctrlWrite(8'd8, 64'd0);
    idle();
    ctrlWrite(8'd8, 64'd5);
    retire(64'h3038, 0);
    ctrlWrite(8'd8, 64'd0);
    drainCheck("wfi_drain");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      wa = 8'($urandom % 13);
      case (wa)
        8'd0, 8'd1, 8'd4, 8'd5: wd = 64'($urandom % 2);
        8'd8:                   wd = ($urandom % 3 == 0) ? 64'd1 : 64'd0;
        default:                wd = pcs[$urandom % 6];
      endcase
      applyStimulus($urandom % 4 != 0,
                    ($urandom % 5 == 0) ? {$urandom, $urandom} : pcs[$urandom % 6],
                    ($urandom % 12 == 0) ? WFI : $urandom,
                    $urandom % 4 != 0, $urandom % 4 == 0,
                    $urandom % 6 == 0, wa, wd,
                    $urandom % 5 == 0, 8'($urandom % 14));
    end
    drainCheck("random_drain");

    $display("[TB] reset during a pending write");
    ctrlWrite(8'd8, 64'd0);
    ctrlWrite(8'd0, 64'd0);
    ctrlWrite(8'd1, 64'd0);
    ctrlWrite(8'd4, 64'd0);
    ctrlWrite(8'd5, 64'd0);
    idle();
    idle();
    retire(64'h4000, 0);
    retire(64'h4004, 0);
    rst_n = 0;
    #1;
    checkResetOutputs("midreset");
    modelReset();
    @(posedge clk);
    #2;
    rst_n = 1;
    for (int i = 0; i < 10; i++) idle();
    ctrlRead(8'd9);
    ctrlRead(8'd2);
    ctrlRead(8'd11);
    idle();
    idle();

    checkOutput("trace_queue_empty", 64'(trace_q.size()), 64'd0);
    checkOutput("read_queue_empty", 64'(read_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
